// File: rtl/capture_controller_pkg.sv
// Shared definitions for the capture path: FSM state encoding and depth helper.
package capture_controller_pkg;

  localparam int unsigned STATE_WIDTH = 3;

  // Encoding is shared with the readout unroller and the trigger hub status path.
  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_e;

  // Number of entries in a capture RAM with the given address width.
  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/capture_controller_if.sv
// Control, sample stream, RAM write port and status bundle of the capture controller.
interface capture_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  arm;
  logic                  abort;
  logic                  trigger;
  logic [ADDR_WIDTH-1:0] pre_count;
  logic [ADDR_WIDTH-1:0] post_count;
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  armed;
  logic                  triggered;
  logic                  done;
  logic [ADDR_WIDTH-1:0] trigger_addr;
  logic [ADDR_WIDTH-1:0] start_addr;

  // Upstream side: trigger hub / sample front-end, and the readout consumer.
  modport master (
    output arm, abort, trigger, pre_count, post_count, sample_valid, sample_data,
    input  mem_we, mem_waddr, mem_wdata, armed, triggered, done, trigger_addr, start_addr
  );

  // Capture controller side.
  modport slave (
    input  arm, abort, trigger, pre_count, post_count, sample_valid, sample_data,
    output mem_we, mem_waddr, mem_wdata, armed, triggered, done, trigger_addr, start_addr
  );
endinterface

// File: rtl/capture_addr_gen.sv
// Write pointer with natural wrap, plus trigger/window-start address capture.
module capture_addr_gen #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic                  trig_i,
  input  logic [ADDR_WIDTH-1:0] pre_i,
  output logic [ADDR_WIDTH-1:0] wptr_o,
  output logic [ADDR_WIDTH-1:0] trigger_addr_o,
  output logic [ADDR_WIDTH-1:0] start_addr_o
);
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] trig_q, trig_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;

  // Next pointer/address values; subtraction wraps modulo DEPTH by width.
  always_comb begin
    wptr_d  = wptr_q;
    trig_d  = trig_q;
    start_d = start_q;
    if (clr_i) begin
      wptr_d  = '0;
      trig_d  = '0;
      start_d = '0;
    end else begin
      if (wr_i) begin
        wptr_d = wptr_q + ADDR_WIDTH'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (trig_i) begin
        trig_d  = wptr_q;
        start_d = wptr_q - pre_i;
      end else begin
        trig_d  = trig_q;
        start_d = start_q;
      end
    end
  end

  // Pointer and captured address registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      trig_q  <= '0;
      start_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      trig_q  <= trig_d;
      start_q <= start_d;
    end
  end

  assign wptr_o         = wptr_q;
  assign trigger_addr_o = trig_q;
  assign start_addr_o   = start_q;
endmodule

// File: rtl/capture_controller.sv
// Capture FSM: pre-trigger ring fill, trigger detect, post-trigger count, RAM write port.
module capture_controller
  import capture_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  capture_controller_if.slave cap
);
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 32'd1);

  cap_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pre_q, post_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  arm_ok_s, wr_s, trig_s;
  logic                  armed_s, triggered_s, done_s;
  logic [ADDR_WIDTH:0]   sum_s;
  logic [ADDR_WIDTH-1:0] post_clamp_s, wptr_s;

  // Arm is only honoured from IDLE/DONE and loses to a simultaneous abort.
  assign arm_ok_s = cap.arm && !cap.abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Keep P + 1 + Q within DEPTH so the kept window is never overwritten.
  assign sum_s        = {1'b0, cap.pre_count} + {1'b0, cap.post_count};
  assign post_clamp_s = (sum_s > {1'b0, ADDR_MAX}) ? (ADDR_MAX - cap.pre_count) : cap.post_count;

  // State register, phase counter and latched window sizes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (arm_ok_s) begin
        pre_q  <= cap.pre_count;
        post_q <= post_clamp_s;
      end else begin
        pre_q  <= pre_q;
        post_q <= post_q;
      end
    end
  end

  // Next-state and write-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cap.abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_ok_s) begin
            state_d = ST_PREFILL;
            cnt_d   = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_PREFILL: begin
          if (pre_q == '0) begin
            state_d = ST_WAIT_TRIG;
          end else if (wr_s) begin
            if ((cnt_q + ADDR_WIDTH'(1)) == pre_q) begin
              state_d = ST_WAIT_TRIG;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_s) begin
            state_d = (post_q == '0) ? ST_DONE : ST_POST;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT_TRIG;
          end
        end
        ST_POST: begin
          if (wr_s) begin
            if ((cnt_q + ADDR_WIDTH'(1)) == post_q) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode: write strobe, trigger hit and status flags.
  always_comb begin
    wr_s        = 1'b0;
    trig_s      = 1'b0;
    armed_s     = 1'b0;
    triggered_s = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      ST_PREFILL: begin
        armed_s = 1'b1;
        wr_s    = cap.sample_valid && !cap.abort && (pre_q != '0);
      end
      ST_WAIT_TRIG: begin
        armed_s = 1'b1;
        wr_s    = cap.sample_valid && !cap.abort;
        trig_s  = cap.sample_valid && !cap.abort && cap.trigger;
      end
      ST_POST: begin
        armed_s     = 1'b1;
        triggered_s = 1'b1;
        wr_s        = cap.sample_valid && !cap.abort;
      end
      ST_DONE: begin
        triggered_s = 1'b1;
        done_s      = 1'b1;
      end
      default: begin
        wr_s = 1'b0;
      end
    endcase
  end

  // Registered RAM write port; address/data hold when no write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= wr_s;
      if (wr_s) begin
        mem_waddr_q <= wptr_s;
        mem_wdata_q <= cap.sample_data;
      end else begin
        mem_waddr_q <= mem_waddr_q;
        mem_wdata_q <= mem_wdata_q;
      end
    end
  end

  capture_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (arm_ok_s),
    .wr_i          (wr_s),
    .trig_i        (trig_s),
    .pre_i         (pre_q),
    .wptr_o        (wptr_s),
    .trigger_addr_o(cap.trigger_addr),
    .start_addr_o  (cap.start_addr)
  );

  assign cap.mem_we    = mem_we_q;
  assign cap.mem_waddr = mem_waddr_q;
  assign cap.mem_wdata = mem_wdata_q;
  assign cap.armed     = armed_s;
  assign cap.triggered = triggered_s;
  assign cap.done      = done_s;
endmodule
